// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmit/receive state enum and the default bit period
// (100 MHz clock / 115200 baud) so that uart_tx and the receiver agree.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned DefaultClksPerBit = 868;

endpackage

// File: rtl/uart_baud_cnt.sv
// Reloadable per-bit down-counter.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset, clears the count
//   reload  - load ClksPerBit-1 (start of a new bit period)
//   expired - high while the count is zero, i.e. the last cycle of a bit
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = DefaultClksPerBit
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic expired
);

    localparam int unsigned CntWidth = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

    logic [CntWidth-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= CntWidth'(ClksPerBit - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed directly from a TX FIFO read port.
// Pops one word when the FIFO is not empty, then sends start bit, DataWidth
// data bits LSB first, optional even parity bit, and a stop bit.
// Optional feature: define UART_TX_PARITY_EN to insert the even parity bit.
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous active-high reset
//   empty_i   - TX FIFO empty flag
//   rd_data_i - TX FIFO registered read data, valid the cycle after a pop
//   rd_en_o   - TX FIFO pop strobe
//   tx_o      - registered serial line, idle high
//   busy_o    - high while a frame is being fetched or sent
//   done_o    - one-cycle pulse per completed frame
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = DefaultClksPerBit,
    parameter int unsigned DataWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 empty_i,
    input  logic [DataWidth-1:0] rd_data_i,
    output logic                 rd_en_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned BitIdxWidth = (DataWidth > 1) ? $clog2(DataWidth) : 1;

    if (ClksPerBit < 2) begin : g_bad_clks_per_bit
        $error("uart_tx: ClksPerBit must be at least 2");
    end

    uart_state_e            state, state_next;
    logic                   tx, tx_next;
    logic [DataWidth-1:0]   shreg, shreg_next;
    logic [BitIdxWidth-1:0] bit_idx, bit_idx_next;
    logic                   done, done_next;
    logic                   rd_en;
    logic                   reload;
    logic                   expired;
`ifdef UART_TX_PARITY_EN
    logic                   parity, parity_next;
`endif

    uart_baud_cnt #(
        .ClksPerBit(ClksPerBit)
    ) u_baud_cnt (
        .clk    (clk_i),
        .rst    (rst_i),
        .reload (reload),
        .expired(expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= StIdle;
            tx      <= 1'b1;
            shreg   <= '0;
            bit_idx <= '0;
            done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            shreg   <= shreg_next;
            bit_idx <= bit_idx_next;
            done    <= done_next;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_next;
`endif
        end
    end

    // tx is registered one state ahead: each transition loads the level of
    // the state being entered, so the line and the state change together.
    always_comb begin
        state_next   = state;
        tx_next      = tx;
        shreg_next   = shreg;
        bit_idx_next = bit_idx;
        done_next    = 1'b0;
        rd_en        = 1'b0;
        reload       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity;
`endif
        case (state)
            StIdle: begin
                tx_next = 1'b1;
                // Reset wins over a pending word so no pop is lost to reset.
                if (!empty_i && !rst_i) begin
                    rd_en      = 1'b1;
                    state_next = StFetch;
                end
            end
            StFetch: begin
                shreg_next   = rd_data_i;
                tx_next      = 1'b0;
                bit_idx_next = '0;
                reload       = 1'b1;
                state_next   = StStart;
`ifdef UART_TX_PARITY_EN
                parity_next  = ^rd_data_i;
`endif
            end
            StStart: begin
                if (expired) begin
                    reload     = 1'b1;
                    tx_next    = shreg[0];
                    shreg_next = shreg >> 1;
                    state_next = StData;
                end
            end
            StData: begin
                if (expired) begin
                    reload = 1'b1;
                    if (bit_idx == BitIdxWidth'(DataWidth - 1)) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity;
                        state_next = StParity;
`else
                        tx_next    = 1'b1;
                        state_next = StStop;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        tx_next      = shreg[0];
                        shreg_next   = shreg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (expired) begin
                    reload     = 1'b1;
                    tx_next    = 1'b1;
                    state_next = StStop;
                end
            end
`endif
            StStop: begin
                if (expired) begin
                    done_next  = 1'b1;
                    state_next = StIdle;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = StIdle;
            end
        endcase
    end

    assign rd_en_o = rd_en;
    assign tx_o    = tx;
    assign busy_o  = (state != StIdle);
    assign done_o  = done;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter ClksPerBit, default 868, SHALL set clock cycles per serial bit (100 MHz / 115200 baud).
REQ-002 Parameter DataWidth, default 8, SHALL set payload bits per frame.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 empty_i  input  1  SHALL be the TX FIFO empty flag.
REQ-006 rd_data_i  input  DataWidth  SHALL be the TX FIFO registered read data, valid the cycle after a pop.
REQ-007 rd_en_o  output  1  SHALL be the TX FIFO pop strobe.
REQ-008 tx_o  output  1  SHALL be the registered serial line, idle high.
REQ-009 busy_o  output  1  SHALL be high whenever a frame is being fetched or sent.
REQ-010 done_o  output  1  SHALL pulse high one cycle per completed frame.

Function
REQ-011 States SHALL be IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-012 IDLE with empty_i=0: rd_en_o=1 for exactly that cycle, next state FETCH; rd_en_o SHALL be 0 in every other state and cycle.
REQ-013 FETCH: rd_data_i captured into shift register, tx_o<=0, bit counter cleared, next state START; start bit visible on tx_o 2 cycles after the rd_en_o cycle.
REQ-014 START, each DATA bit, PARITY and STOP SHALL each hold tx_o for exactly ClksPerBit cycles, timed by a down-counter reloaded at each bit boundary.
REQ-015 DATA SHALL send bit 0 first, DataWidth bits, then go to PARITY (macro defined) or STOP.
REQ-016 STOP SHALL drive tx_o=1; on expiry state returns to IDLE and done_o pulses in that same cycle.
REQ-017 Back-to-back frames: tx_o stays high for ClksPerBit+2 cycles between frames (STOP plus IDLE and FETCH cycles).
REQ-018 empty_i SHALL be ignored outside IDLE; a non-empty FIFO never aborts a frame in progress.
REQ-019 busy_o SHALL be 1 in all states except IDLE.
REQ-020 Bit-cycle counter SHALL be $clog2(ClksPerBit) bits wide; bit index counter $clog2(DataWidth) bits wide.
REQ-021 ClksPerBit < 2 SHALL raise an elaboration-time error.

Reset
REQ-022 rst_i SHALL force state IDLE, tx_o=1, rd_en_o=0, busy_o=0, done_o=0, counters and shift register zero.
REQ-023 Reset mid-frame SHALL drive tx_o=1 on the next cycle; the popped byte is discarded, no extra pop issued.
REQ-024 Reset SHALL dominate all other inputs in the same cycle.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: PARITY state sends even parity (XOR of data bits) for ClksPerBit cycles between DATA and STOP; frame = DataWidth+3 bits.
REQ-026 Macro undefined: PARITY state and parity logic absent, DATA goes directly to STOP; frame = DataWidth+2 bits.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum typedef and the default ClksPerBit constant, shared with the receiver.
REQ-028 Sub-module uart_baud_cnt SHALL implement the reloadable per-bit down-counter with an expiry pulse.
REQ-029 uart_tx SHALL connect directly to the existing fifo read port without glue logic.

Verification
REQ-030 ClksPerBit=4, empty_i falls, rd_data_i=8'hA5 -> rd_en_o single pulse; tx_o sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles; done_o one pulse.
REQ-031 Parity build, byte 8'h07 -> parity bit 1 after data; byte 8'h03 -> parity bit 0; frame 44 cycles at ClksPerBit=4.
REQ-032 FIFO with 3 bytes (8'h00, 8'hFF, 8'h55) -> 3 frames, 3 pops, tx_o high exactly ClksPerBit+2 cycles between frames.
REQ-033 rst_i asserted during bit 3 of DATA -> tx_o=1, busy_o=0 next cycle; no further pop until empty_i=0 seen in IDLE.
REQ-034 empty_i held 1 for 1000 cycles -> rd_en_o, busy_o, done_o stay 0; tx_o stays 1.
